// File: rtl/led_pattern_seq.sv
// LED pattern generator: prescaled steps through COUNT/SCAN/FILL/BLINK, leds/mode registered, step_en freezes all stepping.
// Optional PWM dimming of the leds output is compiled in with `define LED_PWM_EN.
module led_pattern_seq #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned MODE_TICKS = 16,
  parameter int unsigned PWM_DUTY   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  output logic [7:0] leds,
  output logic [1:0] mode
);

  localparam int unsigned PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W = (MODE_TICKS > 2) ? $clog2(MODE_TICKS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MODE_TICKS - 1);

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [PRE_W-1:0]  pre_q,  pre_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        pat_q,  pat_d;
  logic              dir_q,  dir_d;

  logic       tick;
  logic       advance;
  logic [7:0] scan_next;

  function automatic logic [7:0] entry_value(input logic [1:0] m);
    logic [7:0] v;
    case (m)
      MODE_COUNT: v = 8'h00;
      MODE_SCAN:  v = 8'h01;
      MODE_FILL:  v = 8'h01;
      default:    v = 8'h55;
    endcase
    return v;
  endfunction

  always_comb begin
    tick    = (pre_q == PRE_LAST) && step_en;
    advance = tick && (step_q == STEP_LAST);

    pre_d = pre_q;
    if (step_en) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    step_d = step_q;
    if (tick) begin
      step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
    end

    mode_d = advance ? mode_q + 2'd1 : mode_q;

    scan_next = (dir_q == DIR_LEFT) ? {pat_q[6:0], 1'b0} : {1'b0, pat_q[7:1]};

    pat_d = pat_q;
    dir_d = dir_q;
    if (advance) begin
      pat_d = entry_value(mode_d);
      if (mode_d == MODE_SCAN) begin
        dir_d = DIR_LEFT;
      end
    end else if (tick) begin
      case (mode_q)
        MODE_COUNT: pat_d = pat_q + 8'd1;
        MODE_SCAN: begin
          pat_d = scan_next;
          // Reverse on reaching an end so each end shows for exactly one step.
          if (scan_next == 8'h80) begin
            dir_d = DIR_RIGHT;
          end else if (scan_next == 8'h01) begin
            dir_d = DIR_LEFT;
          end
        end
        MODE_FILL:  pat_d = (pat_q == 8'hFF) ? 8'h00 : {pat_q[6:0], 1'b1};
        default:    pat_d = ~pat_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      step_q <= '0;
      mode_q <= MODE_COUNT;
      pat_q  <= 8'h00;
      dir_q  <= DIR_LEFT;
    end else begin
      pre_q  <= pre_d;
      step_q <= step_d;
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
    end
  end

  assign mode = mode_q;

`ifdef LED_PWM_EN
  localparam logic [4:0] DUTY = 5'((PWM_DUTY > 16) ? 16 : PWM_DUTY);

  logic [3:0] pwm_q, pwm_d;
  logic [7:0] leds_q, leds_d;

  // Gate with the next PWM count so leds_q always equals pat_q masked by pwm_q.
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    leds_d = pat_d & {8{({1'b0, pwm_d} < DUTY)}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q  <= 4'd0;
      leds_q <= 8'h00;
    end else begin
      pwm_q  <= pwm_d;
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;
`else
  if (PWM_DUTY > 16) begin : g_pwm_duty_ignored
  end

  assign leds = pat_q;
`endif

endmodule
